// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed LSB-first, DIGIT bits per clock,
// through a single DIGIT-bit carry chain with a start/done handshake.
module serial_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = $clog2(NDIG + 1);

  if ((DIGIT < 1) || (WIDTH < 2) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic                   w_accept;
  logic                   w_last;
  logic [DIGIT:0]         w_dsum;
  logic [WIDTH+DIGIT-1:0] w_res_cat;
  logic [WIDTH-1:0]       w_res_next;
  logic                   w_msb_cin;

  assign w_accept = start && (r_state != StRun);
  assign w_last   = (r_state == StRun) && (r_cnt == CW'(NDIG - 1));

  assign w_dsum     = {1'b0, r_opa[DIGIT-1:0]} + {1'b0, r_opb[DIGIT-1:0]} +
                      {{DIGIT{1'b0}}, r_carry};
  // Concatenate then slice so DIGIT == WIDTH needs no special case.
  assign w_res_cat  = {w_dsum[DIGIT-1:0], r_res};
  assign w_res_next = w_res_cat[WIDTH+DIGIT-1:DIGIT];
  // Carry into the top bit, recovered from that bit's sum and operand bits.
  assign w_msb_cin  = w_dsum[DIGIT-1] ^ r_opa[DIGIT-1] ^ r_opb[DIGIT-1];

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  w_state_next = start ? StRun : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_opa   <= A;
      r_opb   <= B ^ {WIDTH{Sub}};
      r_carry <= Cin ^ Sub;
      r_cnt   <= '0;
    end else if (r_state == StRun) begin
      r_opa   <= r_opa >> DIGIT;
      r_opb   <= r_opb >> DIGIT;
      r_res   <= w_res_next;
      r_carry <= w_dsum[DIGIT];
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= w_res_next;
        r_cout <= w_dsum[DIGIT];
        r_ovf  <= w_msb_cin ^ w_dsum[DIGIT];
      end
    end
  end

  assign busy     = (r_state == StRun);
  assign done     = (r_state == StDone);
  assign Sum      = r_sum;
  assign Cout     = r_cout;
  assign Overflow = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub: a DIGIT=1 and a DIGIT=4 instance, both WIDTH=8.
module tb_serial_addsub;

  logic       clk;
  logic       rst_n;
  logic       start1, start4;
  logic [7:0] a, b;
  logic       sub, cin;
  logic       busy1, done1, cout1, ovf1;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum1, sum4;

  int checks   = 0;
  int failures = 0;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a), .B(b), .Sub(sub), .Cin(cin),
    .busy(busy1), .done(done1), .Sum(sum1), .Cout(cout1), .Overflow(ovf1)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a), .B(b), .Sub(sub), .Cin(cin),
    .busy(busy4), .done(done4), .Sum(sum4), .Cout(cout4), .Overflow(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one start pulse; returns just after the accept edge.
  task automatic launch(input bit d4, input logic [7:0] ia, input logic [7:0] ib,
                        input logic isub, input logic icin);
    a = ia; b = ib; sub = isub; cin = icin;
    if (d4) start4 = 1'b1; else start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  // Cycles until done is seen (bounded), and how many of those cycles had busy high.
  task automatic wait_done(input bit d4, output int n, output int nb);
    n = 0;
    nb = 0;
    while (((d4 ? done4 : done1) !== 1'b1) && (n < 40)) begin
      if ((d4 ? busy4 : busy1) === 1'b1) nb++;
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({sum1, cout1, ovf1, busy1, done1} !== 12'h000) begin
      failures++; $display("FAIL reset_dut1 got=%h exp=000", {sum1, cout1, ovf1, busy1, done1});
    end
    checks++;
    if ({sum4, cout4, ovf4, busy4, done4} !== 12'h000) begin
      failures++; $display("FAIL reset_dut4 got=%h exp=000", {sum4, cout4, ovf4, busy4, done4});
    end
  endtask

  task automatic test_add();
    int n, nb;
    launch(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0);
    checks++;
    if (busy1 !== 1'b1) begin failures++; $display("FAIL add_busy_at_accept got=%b exp=1", busy1); end
    wait_done(1'b0, n, nb);
    checks++;
    if (n != 8) begin failures++; $display("FAIL add_latency got=%0d exp=8", n); end
    checks++;
    if (nb != 8) begin failures++; $display("FAIL add_busy_cycles got=%0d exp=8", nb); end
    checks++;
    if ({sum1, cout1, ovf1} !== {8'h96, 1'b0, 1'b1}) begin
      failures++; $display("FAIL add_result got=%h/%b/%b exp=96/0/1", sum1, cout1, ovf1);
    end
    checks++;
    if (busy1 !== 1'b0) begin failures++; $display("FAIL add_busy_in_done got=%b exp=0", busy1); end
    tick();
    checks++;
    if (done1 !== 1'b0) begin failures++; $display("FAIL add_done_width got=%b exp=0", done1); end
  endtask

  task automatic test_sub();
    int n, nb;
    launch(1'b0, 8'h10, 8'h20, 1'b1, 1'b0);
    wait_done(1'b0, n, nb);
    checks++;
    if ({sum1, cout1, ovf1} !== {8'hF0, 1'b0, 1'b0} || n != 8) begin
      failures++; $display("FAIL sub_borrow got=%h/%b/%b n=%0d exp=F0/0/0 n=8", sum1, cout1, ovf1, n);
    end
    tick();
    launch(1'b0, 8'h05, 8'h03, 1'b1, 1'b1);
    wait_done(1'b0, n, nb);
    checks++;
    if ({sum1, cout1, ovf1} !== {8'h01, 1'b1, 1'b0} || n != 8) begin
      failures++; $display("FAIL sub_binin got=%h/%b/%b n=%0d exp=01/1/0 n=8", sum1, cout1, ovf1, n);
    end
    tick();
  endtask

  task automatic test_digit4();
    int n, nb;
    launch(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done(1'b1, n, nb);
    checks++;
    if (n != 2 || nb != 2) begin
      failures++; $display("FAIL d4_latency got=%0d/%0d exp=2/2", n, nb);
    end
    checks++;
    if ({sum4, cout4, ovf4} !== {8'h00, 1'b1, 1'b0}) begin
      failures++; $display("FAIL d4_wrap got=%h/%b/%b exp=00/1/0", sum4, cout4, ovf4);
    end
    tick();
    launch(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0);
    wait_done(1'b1, n, nb);
    checks++;
    if ({sum4, cout4, ovf4} !== {8'h80, 1'b0, 1'b1} || n != 2) begin
      failures++; $display("FAIL d4_ovf got=%h/%b/%b n=%0d exp=80/0/1 n=2", sum4, cout4, ovf4, n);
    end
    tick();
  endtask

  task automatic test_start_in_run();
    int n, nb, extra;
    launch(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0);
    repeat (3) tick();
    a = 8'h00; b = 8'h00; start1 = 1'b1;
    repeat (2) tick();
    start1 = 1'b0;
    wait_done(1'b0, n, nb);
    checks++;
    if (n != 3) begin failures++; $display("FAIL run_ignore_latency got=%0d exp=3", n); end
    checks++;
    if (sum1 !== 8'h96) begin failures++; $display("FAIL run_ignore_sum got=%h exp=96", sum1); end
    extra = 0;
    repeat (12) begin
      tick();
      if (done1 === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin failures++; $display("FAIL run_ignore_no_done got=%0d exp=0", extra); end
  endtask

  task automatic test_async_reset();
    int n, nb, extra;
    launch(1'b0, 8'h11, 8'h22, 1'b0, 1'b0);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sum1, cout1, ovf1, busy1, done1} !== 12'h000) begin
      failures++; $display("FAIL async_rst got=%h exp=000", {sum1, cout1, ovf1, busy1, done1});
    end
    tick();
    rst_n = 1'b1;
    extra = 0;
    repeat (12) begin
      tick();
      if (done1 === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", extra); end
    launch(1'b0, 8'h01, 8'h01, 1'b0, 1'b0);
    wait_done(1'b0, n, nb);
    checks++;
    if (sum1 !== 8'h02 || n != 8) begin
      failures++; $display("FAIL post_rst_sum got=%h n=%0d exp=02 n=8", sum1, n);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n, nb;
    a = 8'h5A; b = 8'h3C; sub = 1'b0; cin = 1'b0; start1 = 1'b1;
    tick();
    a = 8'h80; b = 8'h80;
    wait_done(1'b0, n, nb);
    checks++;
    if (sum1 !== 8'h96 || n != 8) begin
      failures++; $display("FAIL b2b_first got=%h n=%0d exp=96 n=8", sum1, n);
    end
    tick();
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      failures++; $display("FAIL b2b_accept busy/done got=%b/%b exp=1/0", busy1, done1);
    end
    checks++;
    if (sum1 !== 8'h96) begin failures++; $display("FAIL b2b_sum_hold got=%h exp=96", sum1); end
    // Second done: 8 RUN cycles after the accept edge that closed the first DONE cycle.
    wait_done(1'b0, n, nb);
    checks++;
    if (n != 8 || nb != 8) begin
      failures++; $display("FAIL b2b_spacing got=%0d/%0d exp=8/8", n, nb);
    end
    checks++;
    if ({sum1, cout1, ovf1} !== {8'h00, 1'b1, 1'b1}) begin
      failures++; $display("FAIL b2b_result got=%h/%b/%b exp=00/1/1", sum1, cout1, ovf1);
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    repeat (2) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_add();
    test_sub();
    test_digit4();
    test_start_in_run();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
